// File: rtl/prim_arbiter_wrr_pkt.sv
// Weighted round-robin packet arbiter: N requesters share one valid/ready sink.
// A winner keeps the sink until its last beat; each port gets up to weight packets per turn.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_i, last_i      per-port beat valid and last-beat flag
//   data_i, weight_i   per-port beat data and packets-per-turn (0 acts as 1)
//   gnt_o, idx_o       one-hot accept strobe and index of the current winner
//   valid_o, data_o    beat to the sink, with last_o
//   ready_i            sink ready
//   busy_o             arbiter locked to an owner mid-packet
module prim_arbiter_wrr_pkt #(
   parameter int N       = 4,
   parameter int DW      = 32,
   parameter int WeightW = 4,
   parameter int IdxW    = $clog2(N)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N-1:0]       req_i,
   input  logic [N-1:0]       last_i,
   input  logic [DW-1:0]      data_i [N],
   input  logic [WeightW-1:0] weight_i [N],
   output logic [N-1:0]       gnt_o,
   output logic [IdxW-1:0]    idx_o,
   output logic               valid_o,
   output logic [DW-1:0]      data_o,
   output logic               last_o,
   input  logic               ready_i,
   output logic               busy_o
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t             state, state_nxt;
   logic [IdxW-1:0]    ptr, ptr_nxt;
   logic [IdxW-1:0]    owner, owner_nxt;
   logic [WeightW-1:0] pkt_cnt, cnt_nxt;

   logic [IdxW-1:0]    scan_w;
   logic               scan_hit;
   logic [IdxW:0]      sum;
   logic [IdxW-1:0]    sel;
   logic               valid;
   logic               accept;
   logic               done;
   logic [WeightW-1:0] effw;
   logic [WeightW:0]   cnt_inc;
   logic [IdxW-1:0]    sel_inc;
   logic [N-1:0]       owner_mask;

   // Rotating priority scan starting at ptr, wrapping past N-1.
   always_comb begin
      scan_w   = ptr;
      scan_hit = 1'b0;
      sum      = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IdxW+1)'(k);
         if (sum >= (IdxW+1)'(N)) sum = sum - (IdxW+1)'(N);
         if (!scan_hit && req_i[sum[IdxW-1:0]]) begin
            scan_hit = 1'b1;
            scan_w   = sum[IdxW-1:0];
         end
      end
   end

   assign sel     = (state == LOCK) ? owner : scan_w;
   assign valid   = (state == LOCK) ? req_i[owner] : |req_i;
   assign accept  = valid & ready_i;
   assign done    = accept & last_i[sel];

   assign idx_o   = sel;
   assign valid_o = valid;
   assign data_o  = valid ? data_i[sel] : '0;
   assign last_o  = valid & last_i[sel];
   assign busy_o  = (state == LOCK);

   always_comb begin
      gnt_o      = '0;
      owner_mask = '0;
      if (accept) gnt_o[sel] = 1'b1;
      owner_mask[owner] = 1'b1;
   end

   // Packet-completion bookkeeping; weight is only looked at here.
   assign effw    = (weight_i[sel] == '0) ? WeightW'(1) : weight_i[sel];
   assign cnt_inc = (sel == ptr) ? {1'b0, pkt_cnt} + 1'b1
                                 : (WeightW+1)'(1);
   assign sel_inc = (sel == IdxW'(N-1)) ? '0 : sel + 1'b1;

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      cnt_nxt   = pkt_cnt;
      unique case (state)
         IDLE: begin
            if (valid && !done) begin
               state_nxt = LOCK;
               owner_nxt = sel;
            end
         end
         LOCK: begin
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (done) begin
         if (cnt_inc >= {1'b0, effw}) begin
            ptr_nxt = sel_inc;
            cnt_nxt = '0;
         end else begin
            ptr_nxt = sel;
            cnt_nxt = cnt_inc[WeightW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         ptr     <= '0;
         pkt_cnt <= '0;
         owner   <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         pkt_cnt <= cnt_nxt;
         owner   <= owner_nxt;
      end
   end

   a_gnt_onehot: assert property (
      @(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));

   a_stall_stable: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (valid_o && !ready_i) |=> ($stable(idx_o) && $stable(data_o)));

   a_lock_owner: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (state == LOCK) |-> ((gnt_o & ~owner_mask) == '0));

endmodule
